bitsplit_ctrl: RTL
==================

// Module: bitsplit_ctrl
// PURPOSE
//  Frame-level sequencer for the even/odd bit splitter. Accepts a serial bit stream with a
//  valid/ready handshake and steers alternate bits to the even and odd lanes. It drives the
//  lane-select toggle (tffout) and lane bits for the SIPO stage. It assembles one LANE_W-bit
//  word per lane and presents both words to downstream with a valid/ready handshake.
// PARAMETERS
//  LANE_W   4   bits per lane per frame; a frame is 2*LANE_W serial bits (LANE_W >= 2)
//  TIMEOUT  15  max consecutive din_valid-low cycles tolerated mid-frame before abort (>= 1)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  din        in   1       serial data bit
//  din_sof    in   1       marks din as bit index 0 of a frame; qualified by din_valid
//  din_valid  in   1       din/din_sof valid
//  din_ready  out  1       block accepts a beat this cycle
//  even       out  1       last even-index bit, to SIPO
//  odd        out  1       last odd-index bit, to SIPO
//  tffout     out  1       lane of the last accepted bit: 0 = even, 1 = odd
//  lane_stb   out  1       1-cycle pulse: even/odd/tffout updated this cycle
//  out_even   out  LANE_W  assembled even-lane word, LSB = bit index 0
//  out_odd    out  LANE_W  assembled odd-lane word, LSB = bit index 1
//  out_valid  out  1       out_even/out_odd valid
//  out_ready  in   1       downstream accepts the words
//  frame_err  out  1       1-cycle pulse on protocol error or abort
// BEHAVIOUR
//  Reset (reset == 0, async): state = IDLE.
//   All outputs are 0 except din_ready = 1. Bit counter = 0, idle timer = 0, lane regs = 0.
//  Accept: a beat is accepted when din_valid & din_ready. Only accepted beats count.
//  FSM states: IDLE, COLLECT, DELIVER.
//   IDLE (din_ready = 1):
//    - Accepted beat with sof = 1: the bit is index 0, goes to even lane slot 0; go to COLLECT.
//    - Accepted beat with sof = 0: the beat is dropped and frame_err pulses next cycle.
//   COLLECT (din_ready = 1):
//    - Bit index k: even lane slot k/2 when k is even, else odd lane slot k/2.
//    - sof = 1 on an accepted beat: the partial frame is discarded and frame_err pulses.
//      The beat is taken as index 0 and the FSM stays in COLLECT.
//    - Accepting index 2*LANE_W-1: the next cycle is DELIVER, with out_valid = 1 registered.
//      Latency is 1 cycle from the final accept to out_valid.
//    - Idle timer: increments each cycle din_valid = 0 and clears on any accept.
//      At TIMEOUT: discard the partial frame, frame_err pulses, go to IDLE.
//   DELIVER (din_ready = 0):
//    - out_even/out_odd stay stable while out_valid = 1 and out_ready = 0.
//    - On out_valid & out_ready: out_valid drops the next cycle and the FSM returns to IDLE.
//      din_ready is 1 in that same next cycle. out_even/out_odd keep their last value.
//  SIPO drive: the cycle after each accept, lane_stb = 1.
//   tffout = k[0]. If the lane is even, even = bit; otherwise odd = bit.
//   The unused lane output holds its previous value.
//  Lane word regs are cleared at the start of each frame, on accept of sof.
//  Counter width: $clog2(2*LANE_W). The counter does not wrap mid-frame; it clears on
//   frame completion, abort, or restart.
//  frame_err is registered: 1 cycle after the causing event, never longer than 1 cycle.
//  An async reset mid-frame or mid-DELIVER drops all state immediately. There is no
//   resume after reset.
// TESTING (LANE_W=4, TIMEOUT=15)
//  1. Back-to-back beats 1,0,1,1,0,0,1,0, sof on the first beat
//     -> out_valid 1 cycle after the 8th accept, out_even=4'b1011, out_odd=4'b0010.
//  2. Case 1 with out_ready = 0 for 5 cycles -> words stable, din_ready = 0 throughout.
//     On handshake: out_valid = 0 and din_ready = 1 the next cycle.
//  3. 3 bits, then sof + 8 bits 1,1,1,1,1,1,1,1 -> one frame_err pulse.
//     Then out_even=4'hF, out_odd=4'hF.
//  4. 5 bits, then din_valid low for 15 cycles -> frame_err pulse, FSM back to IDLE.
//     A following full frame is delivered correctly.
//  5. Beat without sof in IDLE -> frame_err pulse, no state change, out_valid stays 0.
//  6. Assert reset during the 6th bit and during DELIVER -> all outputs immediately at their
//     reset values. A fresh frame after release completes normally.

Source files
------------

// File: rtl/bitsplit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bitsplit_ctrl
//  Description : Frame-level sequencer for the even/odd bit splitter. Steers
//                alternate serial bits to the even/odd lanes, drives the SIPO
//                lane-select toggle and assembles one word per lane per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitsplit_ctrl #(
    parameter int LANE_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              din_sof,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              even,
    output logic              odd,
    output logic              tffout,
    output logic              lane_stb,
    output logic [LANE_W-1:0] out_even,
    output logic [LANE_W-1:0] out_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err
);

    localparam int CW = $clog2(2 * LANE_W);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] c_LAST_IDX = CW'(2 * LANE_W - 1);
    localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DELIVER = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [TW-1:0]     r_idle;
    logic [LANE_W-1:0] r_even_w;
    logic [LANE_W-1:0] r_odd_w;
    logic [LANE_W-1:0] r_out_even;
    logic [LANE_W-1:0] r_out_odd;
    logic              r_din_ready;
    logic              r_out_valid;
    logic              r_even;
    logic              r_odd;
    logic              r_tff;
    logic              r_lane_stb;
    logic              r_frame_err;

    logic              w_accept;
    logic              w_store;
    logic [CW-1:0]     w_idx;
    logic [CW-2:0]     w_slot;
    logic [LANE_W-1:0] w_even_nx;
    logic [LANE_W-1:0] w_odd_nx;

    assign w_accept = din_valid & r_din_ready;
    // A beat lands in a lane when it starts a frame or continues one being collected
    assign w_store  = w_accept & (din_sof | (r_state == S_COLLECT));
    // A start-of-frame beat is always index 0, regardless of where the counter is
    assign w_idx    = din_sof ? '0 : r_cnt;
    assign w_slot   = w_idx[CW-1:1];

    // Next lane words: start from scratch on sof, then drop the incoming bit into its slot
    always_comb begin
        w_even_nx = din_sof ? '0 : r_even_w;
        w_odd_nx  = din_sof ? '0 : r_odd_w;
        if (w_idx[0]) begin
            w_odd_nx[w_slot] = din;
        end else begin
            w_even_nx[w_slot] = din;
        end
    end

    // Frame sequencer, SIPO drive and output word registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idle      <= '0;
            r_even_w    <= '0;
            r_odd_w     <= '0;
            r_out_even  <= '0;
            r_out_odd   <= '0;
            r_din_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_even      <= 1'b0;
            r_odd       <= 1'b0;
            r_tff       <= 1'b0;
            r_lane_stb  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_lane_stb  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_store) begin
                r_lane_stb <= 1'b1;
                r_tff      <= w_idx[0];
                if (w_idx[0]) begin
                    r_odd <= din;
                end else begin
                    r_even <= din;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (din_sof) begin
                            r_even_w <= w_even_nx;
                            r_odd_w  <= w_odd_nx;
                            r_cnt    <= CW'(1);
                            r_idle   <= '0;
                            r_state  <= S_COLLECT;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (w_accept) begin
                        r_idle   <= '0;
                        r_even_w <= w_even_nx;
                        r_odd_w  <= w_odd_nx;
                        if (din_sof) begin
                            // Restart: the partial frame is thrown away
                            r_frame_err <= 1'b1;
                            r_cnt       <= CW'(1);
                        end else if (r_cnt == c_LAST_IDX) begin
                            r_out_even  <= w_even_nx;
                            r_out_odd   <= w_odd_nx;
                            r_out_valid <= 1'b1;
                            r_din_ready <= 1'b0;
                            r_cnt       <= '0;
                            r_state     <= S_DELIVER;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end else if (r_idle == c_TO_LAST) begin
                        // Source stalled too long mid-frame: abort
                        r_frame_err <= 1'b1;
                        r_cnt       <= '0;
                        r_idle      <= '0;
                        r_even_w    <= '0;
                        r_odd_w     <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_idle <= r_idle + TW'(1);
                    end
                end

                S_DELIVER: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_din_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_din_ready <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign din_ready = r_din_ready;
    assign even      = r_even;
    assign odd       = r_odd;
    assign tffout    = r_tff;
    assign lane_stb  = r_lane_stb;
    assign out_even  = r_out_even;
    assign out_odd   = r_out_odd;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
